mmio_console_responder: RTL and testbench

Memory-mapped console peripheral. It is the responder on the CPU data bus (AddressBus / DataBusOut / DataBusIn / ControlBus) and sits beside DataMemory, decoding a 16-byte address window. CPU stores to TXDATA push bytes into an internal FIFO. A drain FSM emits the bytes one at a time on a valid/ready byte stream toward a console or serial transmitter. Loads return status and counters; the top level uses Hit to mux this block's read data onto DataBusIn.

---
 rtl/mmio_console_responder.sv | 156 +++++++++++++++
 tb/tb_mmio_console_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console_responder.sv
// Memory-mapped console responder: CPU stores to TXDATA fill a byte FIFO,
// a drain FSM streams bytes out on a valid/ready interface with an idle gap
// after every byte. Status, control and a transmitted-byte counter are readable.
module mmio_console_responder #(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [WIDTH-1:0]      BASE_ADDR  = WIDTH'(32'h0000_F000),
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter int unsigned           GAP_CYCLES = 4
) (
  input  logic             InputClk,
  input  logic             rst,
  input  logic [WIDTH-1:0] AddressBus,
  input  logic [WIDTH-1:0] DataBusOut,
  input  logic [2:0]       ControlBus,
  output logic [WIDTH-1:0] DataBusIn,
  output logic             Hit,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } drainState_e;

  drainState_e      state;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   fifoCount;
  logic             overflow;
  logic             drainEnable;
  logic [31:0]      txCount;
  logic [GAP_W-1:0] gapCnt;

  logic        rdEn;
  logic        wrEn;
  logic [1:0]  regSel;
  logic        fifoEmpty;
  logic        fifoFull;
  logic        pushReq;
  logic        pushOk;
  logic        pop;
  logic        ctrlWr;
  logic [31:0] rdData;
  logic        unusedBits;

  assign Hit       = (AddressBus[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign rdEn      = Hit & ControlBus[1];
  assign wrEn      = Hit & ControlBus[2];
  assign regSel    = AddressBus[3:2];
  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == (PTR_W + 1)'(FIFO_DEPTH));
  assign pushReq   = wrEn && (regSel == 2'd0);
  assign pop       = (state == IDLE) && drainEnable && !fifoEmpty;
  // A same-edge pop frees the slot, so a push into a full FIFO still lands.
  assign pushOk    = pushReq && (!fifoFull || pop);
  assign ctrlWr    = wrEn && (regSel == 2'd2);

  // Byte address bits, the CPU's spare control bit and upper store data are not decoded.
  assign unusedBits = ^{ControlBus[0], AddressBus[1:0], DataBusOut[WIDTH-1:8]};

  // FIFO storage write port; contents need no reset since pointers define validity.
  always_ff @(posedge InputClk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= DataBusOut[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and drain enable.
  always_ff @(posedge InputClk or negedge rst) begin
    if (!rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      overflow    <= 1'b0;
      drainEnable <= 1'b1;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({pushOk, pop})
        2'b10:   fifoCount <= fifoCount + (PTR_W + 1)'(1);
        2'b01:   fifoCount <= fifoCount - (PTR_W + 1)'(1);
        default: fifoCount <= fifoCount;
      endcase
      // A dropped byte on the same edge as a clear leaves the flag set.
      if (pushReq && fifoFull && !pop) begin
        overflow <= 1'b1;
      end else if (ctrlWr && DataBusOut[1]) begin
        overflow <= 1'b0;
      end
      if (ctrlWr) begin
        drainEnable <= DataBusOut[0];
      end
    end
  end

  // Drain FSM: pop a byte, hold it until accepted, then idle for the gap.
  always_ff @(posedge InputClk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      txCount  <= '0;
      gapCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= fifoMem[rdPtr];
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            txCount  <= txCount + 32'd1;
            gapCnt   <= GAP_W'(GAP_CYCLES - 1);
            state    <= GAP;
          end
        end
        GAP: begin
          if (gapCnt == '0) begin
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency register read mux; pre-edge values are returned during a write.
  always_comb begin
    rdData = '0;
    case (regSel)
      2'd1:    rdData = {16'h0000, 8'(fifoCount), 4'h0, tx_valid, overflow, fifoFull, fifoEmpty};
      2'd2:    rdData = {31'h0, drainEnable};
      2'd3:    rdData = txCount;
      default: rdData = '0;
    endcase
    DataBusIn = rdEn ? WIDTH'(rdData) : '0;
  end

endmodule

// File: tb/tb_mmio_console_responder.sv
// Scoreboard bench for mmio_console_responder: bytes expected on the stream
// are queued when stored, and compared as the sink accepts them.
module tb_mmio_console_responder;

  logic        InputClk = 1'b0;
  logic        rst;
  logic [31:0] AddressBus;
  logic [31:0] DataBusOut;
  logic [2:0]  ControlBus;
  logic [31:0] DataBusIn;
  logic        Hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  logic [7:0]  expQ[$];
  int unsigned acceptCyc[$];
  logic [31:0] rd;

  mmio_console_responder #(
    .WIDTH      (32),
    .BASE_ADDR  (32'h0000_F000),
    .FIFO_DEPTH (8),
    .GAP_CYCLES (4)
  ) dut (
    .InputClk   (InputClk),
    .rst        (rst),
    .AddressBus (AddressBus),
    .DataBusOut (DataBusOut),
    .ControlBus (ControlBus),
    .DataBusIn  (DataBusIn),
    .Hit        (Hit),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 InputClk = ~InputClk;

  always @(posedge InputClk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge InputClk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    AddressBus = addr;
    DataBusOut = data;
    ControlBus = 3'b100;
    @(posedge InputClk);
    #1;
    ControlBus = 3'b000;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    AddressBus = addr;
    ControlBus = 3'b010;
    #1;
    data = DataBusIn;
    ControlBus = 3'b000;
  endtask

  // Sink side: inputs are stable between negedge and the next posedge, so a
  // valid&ready seen here is the handshake taken on the coming rising edge.
  always @(negedge InputClk) begin
    if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      acceptCyc.push_back(cyc);
      checkEq("sb_pending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) checkEq("sb_byte", 32'(tx_data), 32'(expQ.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abc [3];
    abc = '{8'h41, 8'h42, 8'h43};
    AddressBus = '0;
    DataBusOut = '0;
    ControlBus = '0;
    tx_ready   = 1'b0;
    rst        = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);

    // Reset state
    busRead(32'h0000_F004, rd); checkEq("rst_status", rd, 32'h0000_0001);
    busRead(32'h0000_F008, rd); checkEq("rst_ctrl", rd, 32'h0000_0001);
    busRead(32'h0000_F00C, rd); checkEq("rst_txcount", rd, 32'h0000_0000);
    checkEq("rst_valid", 32'(tx_valid), 32'd0);
    tick(1);

    // Single byte with the sink ready
    tx_ready = 1'b1;
    expQ.push_back(8'h41);
    busWrite(32'h0000_F000, 32'h1234_5641);
    checkEq("t1_valid_at_push", 32'(tx_valid), 32'd0);
    tick(1);
    checkEq("t1_valid", 32'(tx_valid), 32'd1);
    checkEq("t1_data", 32'(tx_data), 32'h41);
    tick(1);
    checkEq("t1_valid_drop", 32'(tx_valid), 32'd0);
    busRead(32'h0000_F00C, rd); checkEq("t1_txcount", rd, 32'd1);
    tick(8);
    checkEq("t1_drained", 32'(expQ.size()), 32'd0);
    busRead(32'h0000_F004, rd); checkEq("t1_status", rd, 32'h0000_0001);
    tick(1);

    // Back-pressure then release
    tx_ready = 1'b0;
    foreach (abc[i]) begin
      expQ.push_back(abc[i]);
      busWrite(32'h0000_F000, {24'h0, abc[i]});
    end
    tick(3);
    checkEq("bp_hold_valid", 32'(tx_valid), 32'd1);
    checkEq("bp_hold_data", 32'(tx_data), 32'h41);
    busRead(32'h0000_F004, rd); checkEq("bp_status", rd, 32'h0000_0208);
    acceptCyc.delete();
    tx_ready = 1'b1;
    tick(30);
    checkEq("bp_accepts", 32'(acceptCyc.size()), 32'd3);
    if (acceptCyc.size() == 3) begin
      checkEq("bp_spacing_ab", acceptCyc[1] - acceptCyc[0], 32'd6);
      checkEq("bp_spacing_bc", acceptCyc[2] - acceptCyc[1], 32'd6);
    end
    checkEq("bp_drained", 32'(expQ.size()), 32'd0);
    busRead(32'h0000_F00C, rd); checkEq("bp_txcount", rd, 32'd4);
    tick(1);

    // Overflow with drain disabled
    busWrite(32'h0000_F008, 32'h0);
    for (int unsigned i = 1; i <= 9; i++) begin
      if (i <= 8) expQ.push_back(8'(i));
      busWrite(32'h0000_F000, 32'(i));
    end
    tick(2);
    busRead(32'h0000_F004, rd); checkEq("ov_status", rd, 32'h0000_0806);
    busWrite(32'h0000_F008, 32'h1);
    tick(60);
    checkEq("ov_drained", 32'(expQ.size()), 32'd0);
    busRead(32'h0000_F00C, rd); checkEq("ov_txcount", rd, 32'd12);
    busRead(32'h0000_F004, rd); checkEq("ov_sticky", rd, 32'h0000_0005);
    busWrite(32'h0000_F008, 32'h3);
    busRead(32'h0000_F004, rd); checkEq("ov_cleared", rd, 32'h0000_0001);
    busRead(32'h0000_F008, rd); checkEq("ov_ctrl_read", rd, 32'h0000_0001);
    tick(1);

    // Full FIFO with a push landing on the pop edge
    tx_ready = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      expQ.push_back(8'(8'h10 + i));
      busWrite(32'h0000_F000, 32'h10 + 32'(i));
    end
    tick(2);
    busRead(32'h0000_F004, rd); checkEq("fp_full", rd, 32'h0000_080A);
    tx_ready = 1'b1;
    tick(5);
    expQ.push_back(8'h19);
    busWrite(32'h0000_F000, 32'h19);
    busRead(32'h0000_F004, rd); checkEq("fp_push_pop", rd, 32'h0000_080A);
    tick(70);
    checkEq("fp_drained", 32'(expQ.size()), 32'd0);
    busRead(32'h0000_F00C, rd); checkEq("fp_txcount", rd, 32'd22);
    busRead(32'h0000_F004, rd); checkEq("fp_status", rd, 32'h0000_0001);
    tick(1);

    // Address decode outside the window
    AddressBus = 32'h0000_F010;
    DataBusOut = 32'h55;
    ControlBus = 3'b110;
    #1;
    checkEq("dec_hit", 32'(Hit), 32'd0);
    checkEq("dec_rdata", DataBusIn, 32'h0);
    @(posedge InputClk);
    #1;
    ControlBus = 3'b000;
    tick(3);
    checkEq("dec_no_tx", 32'(tx_valid), 32'd0);
    busRead(32'h0000_F004, rd); checkEq("dec_status", rd, 32'h0000_0001);
    busRead(32'h0000_F00C, rd); checkEq("dec_txcount", rd, 32'd22);
    tick(1);

    // Simultaneous read and write of CTRL returns the old value
    AddressBus = 32'h0000_F008;
    DataBusOut = 32'h0;
    ControlBus = 3'b110;
    #1;
    checkEq("rw_hit", 32'(Hit), 32'd1);
    checkEq("rw_old_ctrl", DataBusIn, 32'h1);
    @(posedge InputClk);
    #1;
    ControlBus = 3'b000;
    busRead(32'h0000_F008, rd); checkEq("rw_new_ctrl", rd, 32'h0);
    busWrite(32'h0000_F008, 32'h1);

    // Reset during transmission
    tx_ready = 1'b0;
    busWrite(32'h0000_F000, 32'h61);
    busWrite(32'h0000_F000, 32'h62);
    busWrite(32'h0000_F000, 32'h63);
    tick(1);
    checkEq("mr_valid_before", 32'(tx_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkEq("mr_valid_async", 32'(tx_valid), 32'd0);
    checkEq("mr_data_async", 32'(tx_data), 32'h0);
    @(posedge InputClk);
    #1;
    rst = 1'b1;
    tick(2);
    busRead(32'h0000_F004, rd); checkEq("mr_status", rd, 32'h0000_0001);
    busRead(32'h0000_F00C, rd); checkEq("mr_txcount", rd, 32'd0);
    busRead(32'h0000_F008, rd); checkEq("mr_ctrl", rd, 32'h1);
    tick(3);
    checkEq("mr_no_tx", 32'(tx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
